// File: rtl/sync_counter.sv
// Modulo-MOD up/down counter built from per-bit toggle stages, with clear, load, enable and direction.
// Latency: q and wrap are registered and update one clk edge after the controls are sampled. tc is combinational.
// Backpressure: none. The counter steps on every enabled edge. Define SYNC_CNT_SAT_EN to add the sat (saturate) port.
module sync_counter #(
    parameter int     WIDTH = 4,
    parameter longint MOD   = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             up_dn,
`ifdef SYNC_CNT_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    // Largest count value, plus whether the modulus spans the full binary range.
    localparam logic [63:0]      MOD_L      = 64'(MOD);
    localparam logic [63:0]      MAX_L      = 64'(MOD - 1);
    localparam logic [WIDTH-1:0] MAX_VAL    = MAX_L[WIDTH-1:0];
    localparam bit               FULL_RANGE = (MOD == (longint'(1) << WIDTH));

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [WIDTH-1:0] tgl;
    logic [WIDTH-1:0] chain_nxt;
    logic             lo_ones;
    logic             lo_zeros;
    logic             at_max;
    logic             at_zero;
    logic             at_bound;
    logic             sat_hold;

`ifdef SYNC_CNT_SAT_EN
    assign sat_hold = sat;
`else
    assign sat_hold = 1'b0;
`endif

    assign at_max   = (cnt_q == MAX_VAL);
    assign at_zero  = (cnt_q == '0);
    assign at_bound = up_dn ? at_max : at_zero;

    // Toggle chain: bit i flips when every lower bit is at its carry state (all ones up, all zeros down).
    always_comb begin
        tgl      = '0;
        lo_ones  = 1'b1;
        lo_zeros = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            tgl[i]   = en & (up_dn ? lo_ones : lo_zeros);
            lo_ones  = lo_ones & cnt_q[i];
            lo_zeros = lo_zeros & ~cnt_q[i];
        end
        chain_nxt = cnt_q ^ tgl;
    end

    // Next-state selection in priority order clr > load > en > hold. The bound is handled by reload, saturation or the natural chain wrap.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            // An out-of-range load value clamps to the top of the count range.
            if (64'(din) >= MOD_L) begin
                cnt_d = MAX_VAL;
            end else begin
                cnt_d = din;
            end
        end else if (en) begin
            if (at_bound) begin
                if (sat_hold) begin
                    cnt_d = cnt_q;
                end else begin
                    wrap_d = 1'b1;
                    if (FULL_RANGE) begin
                        cnt_d = chain_nxt;
                    end else begin
                        cnt_d = up_dn ? '0 : MAX_VAL;
                    end
                end
            end else begin
                cnt_d = chain_nxt;
            end
        end
    end

    // Count and wrap-pulse registers. Reset clears both without waiting for clk.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = cnt_q;
    assign wrap = wrap_q;
    assign tc   = en & at_bound;

endmodule

// File: tb/tb_sync_counter.sv
module tb_sync_counter;

    logic       clk;
    logic       rstn;
    logic       clr;
    logic       load;
    logic [3:0] din;
    logic       en;
    logic       up_dn;
    logic       sat;

    logic [3:0] q10;
    logic       tc10;
    logic       wrap10;
    logic [3:0] q16;
    logic       tc16;
    logic       wrap16;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int q10;
        bit w10;
        int q16;
        bit w16;
    } exp_t;

    exp_t sb[$];
    int   m10 = 0;
    int   m16 = 0;
    int   wc10 = 0;
    int   wc16 = 0;

    sync_counter #(.WIDTH(4), .MOD(10)) dut10 (
        .clk(clk), .rstn(rstn), .clr(clr), .load(load), .din(din), .en(en), .up_dn(up_dn),
`ifdef SYNC_CNT_SAT_EN
        .sat(sat),
`endif
        .q(q10), .tc(tc10), .wrap(wrap10)
    );

    sync_counter #(.WIDTH(4), .MOD(16)) dut16 (
        .clk(clk), .rstn(rstn), .clr(clr), .load(load), .din(din), .en(en), .up_dn(up_dn),
`ifdef SYNC_CNT_SAT_EN
        .sat(sat),
`endif
        .q(q16), .tc(tc16), .wrap(wrap16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Behavioural reference: plain arithmetic, no toggle chain.
    function automatic void model_next(input int mq, input int mod, input logic c, input logic l,
                                       input int d, input logic e, input logic u, input logic s,
                                       output int nq, output bit nw);
        nq = mq;
        nw = 1'b0;
        if (c) begin
            nq = 0;
        end else if (l) begin
            nq = (d >= mod) ? mod - 1 : d;
        end else if (e) begin
            if (u) begin
                if (mq == mod - 1) begin
                    if (!s) begin nq = 0; nw = 1'b1; end
                end else nq = mq + 1;
            end else begin
                if (mq == 0) begin
                    if (!s) begin nq = mod - 1; nw = 1'b1; end
                end else nq = mq - 1;
            end
        end
    endfunction

    function automatic bit model_tc(input int mq, input int mod, input logic e, input logic u);
        return e && (u ? (mq == mod - 1) : (mq == 0));
    endfunction

    // Drive one cycle of controls, check tc combinationally, push the expectation, then pop and compare after the edge.
    task automatic step(input logic c, input logic l, input logic [3:0] d, input logic e,
                        input logic u, input logic s);
        exp_t x;
        int   nq;
        bit   nw;
        clr = c; load = l; din = d; en = e; up_dn = u; sat = s;
        #1;
        chk("tc10", 32'(tc10), 32'(model_tc(m10, 10, e, u)));
        chk("tc16", 32'(tc16), 32'(model_tc(m16, 16, e, u)));
        model_next(m10, 10, c, l, int'(d), e, u, s, nq, nw);
        x.q10 = nq; x.w10 = nw; m10 = nq;
        model_next(m16, 16, c, l, int'(d), e, u, s, nq, nw);
        x.q16 = nq; x.w16 = nw; m16 = nq;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk("q10", 32'(q10), 32'(x.q10));
        chk("wrap10", 32'(wrap10), 32'(x.w10));
        chk("q16", 32'(q16), 32'(x.q16));
        chk("wrap16", 32'(wrap16), 32'(x.w16));
        wc10 += int'(wrap10);
        wc16 += int'(wrap16);
    endtask

    initial begin
        rstn = 1'b0; clr = 1'b0; load = 1'b0; din = 4'd0; en = 1'b0; up_dn = 1'b1; sat = 1'b0;
        #2;
        chk("rst_q10", 32'(q10), 32'd0);
        chk("rst_wrap10", 32'(wrap10), 32'd0);
        chk("rst_q16", 32'(q16), 32'd0);
        chk("rst_tc10", 32'(tc10), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Continuous up count: MOD=10 wraps twice, MOD=16 once, in 25 cycles.
        for (int i = 0; i < 25; i++) begin
            step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
            if (i == 8) begin
                chk("up_q10_at9", 32'(q10), 32'd9);
                chk("up_tc10_at9", 32'(tc10), 32'd1);
            end
            if (i == 9) chk("up_wrap10_pulse", 32'(wrap10), 32'd1);
        end
        chk("wrap_count10", 32'(wc10), 32'd2);
        chk("wrap_count16", 32'(wc16), 32'd1);
        chk("pre_rst_q16", 32'(q16), 32'd9);

        // Asynchronous reset mid-count, observed before any clk edge.
        rstn = 1'b0;
        #1;
        chk("async_rst_q16", 32'(q16), 32'd0);
        chk("async_rst_wrap16", 32'(wrap16), 32'd0);
        chk("async_rst_q10", 32'(q10), 32'd0);
        m10 = 0;
        m16 = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Down wrap from a loaded 2.
        step(1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("dn_tc10_at0", 32'(tc10), 32'd1);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("dn_q10_wrap_to9", 32'(q10), 32'd9);
        chk("dn_wrap10", 32'(wrap10), 32'd1);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("dn_wrap10_one_cycle", 32'(wrap10), 32'd0);

        // Priority: clr beats load and en, then an out-of-range load clamps.
        step(1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0);
        chk("prio_clr_q10", 32'(q10), 32'd0);
        step(1'b0, 1'b1, 4'd12, 1'b1, 1'b1, 1'b0);
        chk("clamp_q10", 32'(q10), 32'd9);
        chk("clamp_q16", 32'(q16), 32'd12);

        // Hold at 7 with en low, then flip direction every edge.
        step(1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("hold_q10", 32'(q10), 32'd7);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd0, 1'b1, (i % 2 == 0), 1'b0);
        chk("dir_q10", 32'(q10), 32'd7);

`ifdef SYNC_CNT_SAT_EN
        // Saturation: hold at the bound without wrapping, then wrap again once sat drops.
        step(1'b0, 1'b1, 4'd14, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        chk("sat_q16", 32'(q16), 32'd15);
        chk("sat_tc16", 32'(tc16), 32'd1);
        chk("sat_wrap16", 32'(wrap16), 32'd0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        chk("unsat_wrap16", 32'(wrap16), 32'd1);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        chk("sat_dn_q16", 32'(q16), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_counter.md
# sync_counter

Parametrised synchronous modulo-N up/down counter built from per-bit toggle stages, each stage toggling when every lower stage is at its carry state. It adds enable, direction, synchronous clear and parallel load, and provides a terminal-count output and a registered wrap pulse. It is the general counter primitive for timers, dividers and sequencers that cascade counters.

## Interface
- WIDTH, 4, counter width in bits; legal values are 1..32.
- MOD, 16, count modulus; the count range is 0..MOD-1; legal values are 2..2^WIDTH.
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear to 0; highest synchronous priority.
- load  in  1  synchronous parallel load of din.
- din  in  WIDTH  load value.
- en  in  1  count enable.
- up_dn  in  1  direction: 1 counts up, 0 counts down.
- sat  in  1  saturate instead of wrap; present only with SYNC_CNT_SAT_EN.
- q  out  WIDTH  current count, registered.
- tc  out  1  terminal count, combinational.
- wrap  out  1  one-cycle pulse, registered, marking that a wrap occurred.

## Operation
- Per-bit toggle enable, up direction: T[i] = en & (q[i-1:0] all ones).
- Per-bit toggle enable, down direction: T[i] = en & (q[i-1:0] all zeros).
- T[0] = en.
- When MOD = 2^WIDTH, the toggle chain alone produces the natural wrap.
- When MOD < 2^WIDTH, the bound is enforced by a synchronous reload:
  - up at MOD-1 goes to 0;
  - down at 0 goes to MOD-1.
- Synchronous priority at each rising edge is clr > load > en > hold.
  - clr: q becomes 0 and wrap becomes 0.
  - load: q becomes din. If din ≥ MOD, q becomes MOD-1 (clamped). wrap becomes 0.
  - en = 1: q steps by ±1 modulo MOD. wrap becomes 1 only if this step crossed the bound (MOD-1 to 0 up, or 0 to MOD-1 down); otherwise wrap becomes 0.
  - Otherwise: q holds and wrap becomes 0.
- tc = en & (up_dn ? q == MOD-1 : q == 0). tc therefore asserts in the cycle before a wrap, for cascading into the en of the next counter stage.
- A direction change takes effect on the same edge; there is no pipeline.
- A load while en = 1 takes precedence; no step is applied in that cycle.

## Timing
- Reset, with rstn low, applied asynchronously and without waiting for clk:
  - q = 0
  - wrap = 0
  - tc follows q and en (it is combinational).
- Release: the first counting edge is the first rising clk edge after rstn goes high.
- Count latency: q changes one edge after en is sampled high.
- tc is zero-latency (combinational) from q, en and up_dn.
- wrap is high for exactly the one cycle following the edge at which the wrap happened.
- Reset mid-count clears q and wrap immediately; a pending load or clr is discarded.
- Continuous en gives one wrap pulse every MOD cycles.

## Configuration
- Macro: SYNC_CNT_SAT_EN.
- Defined: port sat exists. When sat = 1 and en = 1:
  - up at MOD-1 holds at MOD-1;
  - down at 0 holds at 0;
  - wrap stays 0.
  - tc is still asserted at the bound.
  - When sat = 0, behaviour is identical to the undefined case.
- Undefined: no sat port; the counter always wraps modulo MOD.

## Test plan
- Reset: drive rstn low mid-count at q=9, WIDTH=4, MOD=16 → q=0 and wrap=0 asynchronously, before the next clk edge.
- Up wrap, MOD=10: en=1, up_dn=1 from 0 → q steps 0..9; tc=1 while q=9; the next edge gives q=0 and wrap=1 for one cycle; repeats every 10 cycles.
- Down wrap, MOD=10: load din=2, then en=1, up_dn=0 → q=2,1,0,9; tc=1 at q=0; wrap pulses after the step to 9.
- Priority: clr=1, load=1, din=5, en=1 on the same edge → q=0. Next edge with load=1, din=12 (MOD=10) → q=9 (clamped); wrap=0 on both edges.
- Hold and direction: en=0 for 5 cycles at q=7 → q stays 7 and tc=0. Then toggle up_dn every edge with en=1 → q goes 8,7,8,7.
- With SYNC_CNT_SAT_EN, MOD=16, sat=1, en=1, up_dn=1 from 14 → q=14,15,15,15; wrap never asserts; tc=1 while q=15.
